// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory, fills the IF/ID register.
// One instruction per un-stalled RUN cycle, visible on ifid_* one cycle later; stall holds PC and IF/ID.
module if_fetch_unit #(
   parameter int unsigned IM_ADDR_W = 10,
   parameter int unsigned IM_DEPTH  = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   output logic                 IM_read,
   output logic [IM_ADDR_W-1:0] IM_addr,
   input  logic [31:0]          IM_out,
   output logic [31:0]          ifid_pc,
   output logic [31:0]          ifid_inst,
   output logic                 ifid_valid,
   output logic                 if_fault
);

   localparam logic [31:0] LP_DEPTH = 32'(IM_DEPTH);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_ifid_pc;
   logic [31:0] w_ifid_pc_nxt;
   logic [31:0] r_ifid_inst;
   logic [31:0] w_ifid_inst_nxt;
   logic        r_ifid_valid;
   logic        w_ifid_valid_nxt;
   logic        r_fault;
   logic        w_fault_nxt;
   logic        w_bad;
   logic        w_read;

   // Misaligned or beyond the populated part of the memory.
   assign w_bad = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= LP_DEPTH);

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_inst_nxt  = r_ifid_inst;
      w_ifid_valid_nxt = r_ifid_valid;
      w_fault_nxt      = r_fault;
      w_read           = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_i) begin
               w_pc_nxt         = redirect_pc_i;
               w_ifid_valid_nxt = 1'b0;
            end else if (w_bad) begin
               w_state_nxt      = ST_FAULT;
               w_fault_nxt      = 1'b1;
               w_ifid_valid_nxt = 1'b0;
            end else if (!stall_i) begin
               w_read           = 1'b1;
               w_ifid_inst_nxt  = IM_out;
               w_ifid_pc_nxt    = r_pc;
               w_ifid_valid_nxt = 1'b1;
               w_pc_nxt         = r_pc + 32'd4;
            end
         end
         ST_FAULT: begin
            // Stall is deliberately ignored here; only a redirect restarts fetching.
            if (redirect_i) begin
               w_pc_nxt    = redirect_pc_i;
               w_fault_nxt = 1'b0;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_ifid_pc    <= 32'd0;
         r_ifid_inst  <= 32'd0;
         r_ifid_valid <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ifid_pc    <= w_ifid_pc_nxt;
         r_ifid_inst  <= w_ifid_inst_nxt;
         r_ifid_valid <= w_ifid_valid_nxt;
         r_fault      <= w_fault_nxt;
      end
   end

   assign IM_read    = w_read & ~rst;
   assign IM_addr    = r_pc[IM_ADDR_W+1:2];
   assign ifid_pc    = r_ifid_pc;
   assign ifid_inst  = r_ifid_inst;
   assign ifid_valid = r_ifid_valid;
   assign if_fault   = r_fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Drives two fetch units (1024-word and 4-word memories) with directed then random stimulus.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   logic        rd0, rd1, v0, v1, f0, f1;
   logic [9:0]  addr0;
   logic [1:0]  addr1;
   logic [31:0] out0, out1, ipc0, ipc1, iinst0, iinst1;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   assign out0 = mem[addr0];
   assign out1 = mem[{8'd0, addr1}];

   if_fetch_unit #(.IM_ADDR_W(10), .IM_DEPTH(1024), .RESET_PC(32'h0)) dut0 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .IM_read(rd0), .IM_addr(addr0), .IM_out(out0),
      .ifid_pc(ipc0), .ifid_inst(iinst0), .ifid_valid(v0), .if_fault(f0));

   if_fetch_unit #(.IM_ADDR_W(2), .IM_DEPTH(4), .RESET_PC(32'h0)) dut1 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .IM_read(rd1), .IM_addr(addr1), .IM_out(out1),
      .ifid_pc(ipc1), .ifid_inst(iinst1), .ifid_valid(v1), .if_fault(f1));

   logic        a_rd   [2];
   logic [31:0] a_addr [2];
   logic [31:0] a_ipc  [2];
   logic [31:0] a_inst [2];
   logic        a_v    [2];
   logic        a_f    [2];
   assign a_rd[0] = rd0;   assign a_rd[1] = rd1;
   assign a_addr[0] = {22'd0, addr0};   assign a_addr[1] = {30'd0, addr1};
   assign a_ipc[0] = ipc0; assign a_ipc[1] = ipc1;
   assign a_inst[0] = iinst0; assign a_inst[1] = iinst1;
   assign a_v[0] = v0;     assign a_v[1] = v1;
   assign a_f[0] = f0;     assign a_f[1] = f1;

   // Reference model: one fetcher per instance, described by its observable rules.
   int unsigned depth [2] = '{1024, 4};
   int unsigned amask [2] = '{1023, 3};
   logic [31:0] m_pc   [2];
   logic [31:0] m_ipc  [2];
   logic [31:0] m_inst [2];
   bit          m_boot [2];
   bit          m_fault[2];
   bit          m_v    [2];

   int  n_chk = 0;
   int  n_err = 0;
   bit  armed = 0;
   logic obs_rd [2];

   localparam logic [31:0] A0 = 32'hA000_0000;
   localparam logic [31:0] A1 = 32'hA111_1111;
   localparam logic [31:0] A2 = 32'hA222_2222;
   localparam logic [31:0] A3 = 32'hA333_3333;
   localparam logic [31:0] I16 = 32'hB016_0016;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_bad(int k);
      return (m_pc[k][1:0] != 2'b00) || ((m_pc[k] >> 2) >= depth[k]);
   endfunction

   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] dpc);
      logic exp_rd;
      rst = r; stall_i = s; redirect_i = d; redirect_pc_i = dpc;
      #1;
      for (int k = 0; k < 2; k++) begin
         obs_rd[k] = a_rd[k];
         exp_rd = !r && !m_boot[k] && !m_fault[k] && !d && !m_bad(k) && !s;
         if (armed) begin
            chk($sformatf("IM_read%0d", k), {31'd0, a_rd[k]}, {31'd0, exp_rd});
            chk($sformatf("IM_addr%0d", k), a_addr[k], (m_pc[k] >> 2) & amask[k]);
            chk($sformatf("ifid_pc%0d", k), a_ipc[k], m_ipc[k]);
            chk($sformatf("ifid_inst%0d", k), a_inst[k], m_inst[k]);
            chk($sformatf("ifid_valid%0d", k), {31'd0, a_v[k]}, {31'd0, m_v[k]});
            chk($sformatf("if_fault%0d", k), {31'd0, a_f[k]}, {31'd0, m_fault[k]});
         end
         if (r) begin
            m_pc[k] = 32'h0; m_boot[k] = 1; m_fault[k] = 0;
            m_v[k] = 0; m_ipc[k] = 0; m_inst[k] = 0;
         end else if (m_boot[k]) begin
            m_boot[k] = 0;
         end else if (m_fault[k]) begin
            if (d) begin m_pc[k] = dpc; m_fault[k] = 0; end
         end else if (d) begin
            m_pc[k] = dpc; m_v[k] = 0;
         end else if (m_bad(k)) begin
            m_fault[k] = 1; m_v[k] = 0;
         end else if (!s) begin
            m_inst[k] = mem[10'((m_pc[k] >> 2) & amask[k])];
            m_ipc[k]  = m_pc[k];
            m_v[k]    = 1;
            m_pc[k]   = m_pc[k] + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      if (r) armed = 1;
   endtask

   initial begin
      logic [31:0] tgt;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = A0; mem[1] = A1; mem[2] = A2; mem[3] = A3; mem[16] = I16;

      // Reset, boot cycle, free-run
      step(1, 0, 0, 0);
      chk("rst_ifid_pc", ipc0, 32'h0);
      chk("rst_ifid_inst", iinst0, 32'h0);
      chk("rst_valid", {31'd0, v0}, 32'd0);
      chk("rst_fault", {31'd0, f0}, 32'd0);
      step(0, 0, 0, 0);
      chk("boot_rd", {31'd0, obs_rd[0]}, 32'd0);
      step(0, 0, 0, 0);
      chk("t1_inst_a0", iinst0, A0);
      chk("t1_pc_0", ipc0, 32'h0);
      step(0, 0, 0, 0);
      chk("t1_inst_a1", iinst0, A1);
      chk("t1_pc_4", ipc0, 32'h4);

      // Stall holds PC and IF/ID
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         chk("t2_rd", {31'd0, obs_rd[0]}, 32'd0);
         chk("t2_inst", iinst0, A1);
         chk("t2_valid", {31'd0, v0}, 32'd1);
         chk("t2_addr", {22'd0, addr0}, 32'd2);
      end
      step(0, 0, 0, 0);
      chk("t2_inst_a2", iinst0, A2);
      chk("t2_pc_8", ipc0, 32'h8);

      // Redirect beats stall
      step(0, 1, 1, 32'h40);
      chk("t3_valid", {31'd0, v0}, 32'd0);
      chk("t3_addr", {22'd0, addr0}, 32'h10);
      step(0, 0, 0, 0);
      chk("t3_inst", iinst0, I16);
      chk("t3_pc", ipc0, 32'h40);

      // Misaligned redirect faults the following cycle; only redirect recovers
      step(0, 0, 1, 32'h42);
      step(0, 0, 0, 0);
      chk("t4_fault", {31'd0, f0}, 32'd1);
      chk("t4_valid", {31'd0, v0}, 32'd0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("t4_fault_held", {31'd0, f0}, 32'd1);
      step(0, 0, 1, 32'h8);
      chk("t4_fault_clr", {31'd0, f0}, 32'd0);
      step(0, 0, 0, 0);
      chk("t4_pc_8", ipc0, 32'h8);
      chk("t4_inst", iinst0, A2);

      // Reset out of FAULT, then 4-word memory runs off its end
      step(0, 0, 1, 32'h42);
      step(0, 0, 0, 0);
      chk("t6_fault_pre", {31'd0, f0}, 32'd1);
      step(1, 0, 0, 0);
      chk("t6_fault", {31'd0, f0}, 32'd0);
      chk("t6_valid", {31'd0, v0}, 32'd0);
      chk("t6_pc", ipc0, 32'h0);
      step(0, 0, 0, 0);
      chk("t6_boot_rd", {31'd0, obs_rd[0]}, 32'd0);
      step(0, 0, 0, 0);
      chk("t6_inst_a0", iinst0, A0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t5_inst_a3", iinst1, A3);
      chk("t5_pc_c", ipc1, 32'hC);
      step(0, 0, 0, 0);
      chk("t5_rd", {31'd0, obs_rd[1]}, 32'd0);
      chk("t5_fault", {31'd0, f1}, 32'd1);
      chk("t5_valid", {31'd0, v1}, 32'd0);
      step(0, 0, 0, 0);
      chk("t5_no_fifth", {31'd0, v1}, 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0:       tgt = $urandom;
            1:       tgt = $urandom_range(0, 32'h1FFF);
            2, 3:    tgt = {$urandom_range(0, 7), 2'b00} + 32'h0;
            default: tgt = {$urandom_range(0, 1100), 2'b00};
         endcase
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0,
              tgt);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
